// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared types and defaults for the branch misprediction recovery controller.
package branch_recovery_ctrl_pkg;

  localparam int XLEN_DEF             = 64;
  localparam int ID_W_DEF             = 8;
  localparam int FLUSH_MIN_CYCLES_DEF = 2;
  localparam int CNT_W_DEF            = 32;

  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef logic [ID_W_DEF-1:0] id_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } brc_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/branch_recovery_ctrl_sat_counter.sv
// brc_sat_counter: cycle counter with synchronous clear that stops at MAX.
module brc_sat_counter #(
  parameter int W   = 2,
  parameter int MAX = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  // Clear has priority; otherwise count up until the saturation value.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en && (cnt_reg != MAX_V)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/branch_recovery_ctrl.sv
// branch_recovery_ctrl: IDLE -> FLUSH -> REDIRECT sequencer for misprediction
// recovery. All outputs are decodes of registered state, so no input reaches
// an output combinationally.
// Optional build macro BRANCH_RECOVERY_PERF_EN adds the mispredict and
// recovery-penalty performance counters.
module branch_recovery_ctrl
  import branch_recovery_ctrl_pkg::*;
#(
  parameter int XLEN             = XLEN_DEF,
  parameter int ID_W             = ID_W_DEF,
  parameter int FLUSH_MIN_CYCLES = FLUSH_MIN_CYCLES_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            mp_valid_i,
  input  logic [XLEN-1:0] mp_target_i,
  input  logic [ID_W-1:0] mp_id_i,
  input  logic            drain_done_i,
  output logic            commit_stall_o,
  output logic            flush_o,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o,
  input  logic            redir_ready_i,
  output logic            busy_o,
  output logic [ID_W-1:0] last_mp_id_o
`ifdef BRANCH_RECOVERY_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_mp_cnt_o,
  output logic [CNT_W-1:0] perf_penalty_cnt_o
`endif
);

  localparam int                FCNT_W     = cnt_width(FLUSH_MIN_CYCLES);
  localparam logic [FCNT_W-1:0] FLUSH_EXIT = FCNT_W'(FLUSH_MIN_CYCLES - 1);

  // Refuse nonsensical configurations at elaboration time.
  if (FLUSH_MIN_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("branch_recovery_ctrl: FLUSH_MIN_CYCLES and CNT_W must be >= 1");
  end

  brc_state_t      state_reg, state_next;
  logic [XLEN-1:0] tgt_reg, tgt_next;
  logic [ID_W-1:0] last_id_reg, last_id_next;
  logic            cnt_clr;
  logic            cnt_en;
  logic [FCNT_W-1:0] flush_cnt;

  // Counts flush cycles so the flush is held for at least the minimum.
  brc_sat_counter #(
    .W   (FCNT_W),
    .MAX (FLUSH_MIN_CYCLES)
  ) u_flush_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (flush_cnt)
  );

  // Next-state logic; new mispredicts are only accepted while idle.
  always_comb begin
    state_next   = state_reg;
    tgt_next     = tgt_reg;
    last_id_next = last_id_reg;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (mp_valid_i) begin
          // Redirect targets are halfword aligned; drop bit 0 at capture.
          tgt_next     = {mp_target_i[XLEN-1:1], 1'b0};
          last_id_next = mp_id_i;
          cnt_clr      = 1'b1;
          state_next   = FLUSH;
        end
      end
      FLUSH: begin
        cnt_en = 1'b1;
        // Early drain is ignored until the minimum flush length is reached.
        if ((flush_cnt >= FLUSH_EXIT) && drain_done_i) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redir_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, captured target and debug id registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      tgt_reg     <= '0;
      last_id_reg <= '0;
    end else begin
      state_reg   <= state_next;
      tgt_reg     <= tgt_next;
      last_id_reg <= last_id_next;
    end
  end

  assign flush_o        = (state_reg == FLUSH);
  assign redir_valid_o  = (state_reg == REDIRECT);
  assign busy_o         = (state_reg != IDLE);
  assign commit_stall_o = (state_reg != IDLE);
  assign redir_pc_o     = tgt_reg;
  assign last_mp_id_o   = last_id_reg;

`ifdef BRANCH_RECOVERY_PERF_EN
  logic [CNT_W-1:0] perf_mp_reg;
  logic [CNT_W-1:0] perf_pen_reg;

  // Wrapping counters: accepted mispredicts and cycles spent recovering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_mp_reg  <= '0;
      perf_pen_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && mp_valid_i) begin
        perf_mp_reg <= perf_mp_reg + 1'b1;
      end
      if (state_reg != IDLE) begin
        perf_pen_reg <= perf_pen_reg + 1'b1;
      end
    end
  end

  assign perf_mp_cnt_o      = perf_mp_reg;
  assign perf_penalty_cnt_o = perf_pen_reg;
`endif

  // A mispredict cannot commit while retirement is stalled.
  mp_while_busy_a: assert property (@(posedge clk) disable iff (!rstn)
    !(mp_valid_i && busy_o));

endmodule
